// File: rtl/result_streamer_if.sv
// Stream, control and C-BRAM read signals of result_streamer, bundled as one port.
// The master side is the streamer. The slave side is the host, BRAM and testbench.
interface result_streamer_if #(
  parameter int N = 16
);
  localparam int ADDR_W = $clog2(N * N);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_q;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [31:0]       checksum;

  modport master (
    input  start, bram_q, out_ready,
    output busy, done, bram_addr, out_data, out_valid, out_last, checksum
  );

  modport slave (
    output start, bram_q, out_ready,
    input  busy, done, bram_addr, out_data, out_valid, out_last, checksum
  );
endinterface

// File: rtl/result_streamer.sv
// Drains the NxN C result BRAM row-major onto a valid/ready stream through a 2-entry buffer.
// Optional running checksum of transferred words: define RESULT_STREAMER_CKSUM_EN.
module result_streamer #(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               rst,
  result_streamer_if.master  bus
);
  localparam int WORDS   = N * N;
  localparam int ADDR_W  = $clog2(WORDS);
  localparam int ISSUE_W = ADDR_W + 1;
  localparam logic [ISSUE_W-1:0] LAST_ISSUE = ISSUE_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0]  LAST_EMIT  = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t             state_reg, state_next;
  logic               done_reg, done_next;
  logic [ISSUE_W-1:0] issue_cnt_reg;
  logic [ADDR_W-1:0]  emit_cnt_reg;
  logic               inflight_reg;

  logic [31:0]        fifo_mem_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;

  logic               start_acc;
  logic               push;
  logic               pop;
  logic               issue;
  logic               last_xfer;
  logic [2:0]         pending;

  assign start_acc = (state_reg == S_IDLE) && bus.start;
  assign push      = inflight_reg;
  assign pop       = bus.out_valid && bus.out_ready;
  assign last_xfer = pop && (emit_cnt_reg == LAST_EMIT);

  // Words buffered plus the one in flight, net of this cycle's pop, must leave room.
  assign pending = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
  assign issue   = (state_reg == S_READ) && (pending < 3'd2);

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.start) state_next = S_READ;
      end
      S_READ: begin
        if (issue && (issue_cnt_reg == LAST_ISSUE)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_xfer) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_reg <= '0;
      emit_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (start_acc) begin
        issue_cnt_reg <= '0;
      end else if (issue) begin
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      end
      if (start_acc) begin
        emit_cnt_reg <= '0;
      end else if (pop) begin
        emit_cnt_reg <= last_xfer ? '0 : emit_cnt_reg + 1'b1;
      end
    end
  end

  // Two-entry FIFO; a push into a full buffer cannot occur because issue is throttled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) fifo_mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        fifo_mem_reg[wr_ptr_reg] <= bus.bram_q;
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = done_reg;
  assign bus.bram_addr = (state_reg == S_READ) ? issue_cnt_reg[ADDR_W-1:0] : '0;
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = fifo_mem_reg[rd_ptr_reg];
  assign bus.out_last  = bus.out_valid && (emit_cnt_reg == LAST_EMIT);

`ifdef RESULT_STREAMER_CKSUM_EN
  logic [31:0] cksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_reg <= '0;
    end else if (start_acc) begin
      cksum_reg <= '0;
    end else if (pop) begin
      cksum_reg <= cksum_reg + bus.out_data;
    end
  end

  assign bus.checksum = cksum_reg;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: doc/result_streamer.md
# result_streamer

Drains the N×N 32-bit result matrix from the single-port C result BRAM (address = row·N + col) and emits it row-major on a valid/ready stream toward the host interface. It is the read-side counterpart of the compute unit that fills that BRAM. It sits beside the compute unit; top-level arbitration grants it the C BRAM port only while the compute unit is idle. It absorbs the BRAM's one-cycle read latency and arbitrary downstream backpressure with a 2-entry buffer and never drops or duplicates a word.

## Interface
- N, default 16: matrix dimension; N*N words per drain; ADDR_W = $clog2(N*N).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to drain the matrix; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- bram_addr  out  ADDR_W  C BRAM read address; BRAM q is valid the cycle after the address is presented.
- bram_q  in  32  C BRAM read data.
- out_data  out  32  stream word C[row][col].
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept; a transfer occurs when out_valid && out_ready.
- out_last  out  1  high with word N*N-1.
- checksum  out  32  see Configuration.

## Operation
- States:
  - IDLE → READ on start.
  - READ → DRAIN once the read for address N*N-1 has been issued.
  - DRAIN → IDLE on acceptance of the last word; done pulses in the first IDLE cycle.
- The issue counter is ADDR_W+1 bits and counts 0..N*N. bram_addr equals the counter's low bits while in READ and is held at 0 otherwise.
- Read issue happens in READ only, when (occupancy + inflight − pop_this_cycle) < 2:
  - inflight is 1 if a read was issued in the previous cycle;
  - pop_this_cycle is the current out_valid && out_ready.
- Returned bram_q is written into the 2-entry FIFO on the cycle after issue.
- Simultaneous push and pop: occupancy is unchanged and order is preserved.
- out_data is the FIFO head. out_valid means the FIFO is not empty.
- out_valid stays asserted and out_data stays stable until accepted (no retraction).
- out_last is derived from a separate emit counter (0..N*N−1) that increments on each transfer.
- start asserted while busy is ignored; start asserted in the same cycle as done is accepted.
- The block never writes the BRAM.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, bram_addr=0, checksum=0. Reset clears the FIFO, all counters and inflight, and returns the FSM to IDLE.
- Reset mid-drain aborts immediately. No done pulse is produced, and the next start restarts from address 0.
- start sampled at edge k:
  - busy=1 and bram_addr=0 in cycle k+1;
  - word 0 lands in the FIFO at edge k+3;
  - out_valid=1 from cycle k+3.
- With out_ready held high:
  - one word per cycle, cycles k+3 .. k+N*N+2;
  - done=1 in cycle k+N*N+3; busy=0 from that same cycle.
- With out_ready low: at most 2 words are buffered and reads stall, with no BRAM read outstanding beyond FIFO capacity.
- When out_ready rises, full rate resumes within 1 cycle.

## Configuration
- RESULT_STREAMER_CKSUM_EN defined:
  - checksum holds the mod-2^32 sum of every word transferred in the current drain;
  - it is cleared when start is accepted and is stable from the done cycle until the next accepted start.
- Undefined: checksum is driven constant 0, no accumulator logic is built, and the port list is unchanged.

## Test plan
- Preload C[i] = i·3+1 for N=16, start, out_ready=1 → 256 words 1,4,…,766 in order on cycles k+3..k+258; out_last only on 766; done in k+259.
- Same preload, out_ready random 50% → identical word sequence with no gaps or duplicates; out_data stable while valid && !ready; bram_addr never advances more than 2 beyond the last accepted word index.
- out_ready=0 for 20 cycles after start → out_valid=1 holding word 0, FIFO full, bram_addr frozen; release → words 0,1,2… back-to-back.
- rst=1 during word 100, then start again → outputs reset values the cycle after rst, no done; new drain begins at word 0.
- start pulsed at k+50 during a drain → ignored, exactly 256 words; start in the done cycle → second drain begins.
- With RESULT_STREAMER_CKSUM_EN, preload C[i] = 0xFFFF_FFFF for all i → checksum = 0xFFFF_FF00 at done; without the macro checksum = 0.
